// File: rtl/masked_sbox_layer_seq.sv
// Sequences a d-share 4x32 state through PAR external pipelined masked S-boxes.
// Define SBSEQ_RND_STALL_EN to let rnd_valid stall issue and capture.
module masked_sbox_layer_seq #(
  parameter int unsigned d      = 4,
  parameter int unsigned PAR    = 8,
  parameter int unsigned SB_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [128*d-1:0]     state_in,
  input  logic                 rnd_valid,
  output logic [4*PAR*d-1:0]   sb_in,
  output logic                 sb_en,
  input  logic [4*PAR*d-1:0]   sb_out,
  output logic                 busy,
  output logic                 done,
  output logic [128*d-1:0]     state_out
);

  localparam int unsigned G  = 32 / PAR;
  localparam int unsigned IW = (G > 1) ? $clog2(G) : 1;
  localparam logic [IW-1:0] LastGrp = IW'(G - 1);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

  state_e              state_q;
  logic [IW-1:0]       iss_q;
  logic [IW-1:0]       cap_q;
  logic [SB_LAT-1:0]   vsr_q;
  logic [128*d-1:0]    inbuf_q;
  logic                active;
  logic                cap_fire;

  assign active = (state_q == StFeed) || (state_q == StDrain);

`ifdef SBSEQ_RND_STALL_EN
  assign sb_en = active & rnd_valid;
`else
  logic unused_rnd_valid;
  assign unused_rnd_valid = rnd_valid;
  assign sb_en = active;
`endif

  assign cap_fire = sb_en & vsr_q[SB_LAT-1];

  // Lanes read only the registered input buffer; shares are routed, never combined.
  always_comb begin
    sb_in = '0;
    if (state_q == StFeed) begin
      for (int p = 0; p < int'(PAR); p++) begin
        for (int i = 0; i < 4; i++) begin
          sb_in[(p*4+i)*d +: d] = inbuf_q[(i*32 + int'(iss_q)*int'(PAR) + p)*d +: d];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      iss_q     <= '0;
      cap_q     <= '0;
      vsr_q     <= '0;
      inbuf_q   <= '0;
      state_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      // vsr marks which S-box pipeline slots carry a real group.
      if (sb_en) begin
        vsr_q <= (vsr_q << 1) | SB_LAT'(state_q == StFeed);
        if (vsr_q[SB_LAT-1]) begin
          for (int p = 0; p < int'(PAR); p++) begin
            for (int i = 0; i < 4; i++) begin
              state_out[(i*32 + int'(cap_q)*int'(PAR) + p)*d +: d] <= sb_out[(p*4+i)*d +: d];
            end
          end
          cap_q <= cap_q + 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            inbuf_q <= state_in;
            iss_q   <= '0;
            cap_q   <= '0;
            busy    <= 1'b1;
            state_q <= StFeed;
          end
        end
        StFeed: begin
          if (sb_en) begin
            iss_q <= iss_q + 1'b1;
            if (iss_q == LastGrp) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (cap_fire && (cap_q == LastGrp)) begin
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_masked_sbox_layer_seq.sv
// Directed bench for masked_sbox_layer_seq with a behavioural pipelined S-box stub.
module tb_masked_sbox_layer_seq;

  localparam int unsigned D      = 4;
  localparam int unsigned PAR    = 8;
  localparam int unsigned SB_LAT = 4;
  localparam int unsigned W      = 128 * D;
  localparam int unsigned SW     = 4 * PAR * D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rnd_valid = 1'b1;
  logic [W-1:0]  state_in = '0;
  logic [SW-1:0] sb_in;
  logic [SW-1:0] sb_out;
  logic          sb_en;
  logic          busy;
  logic          done;
  logic [W-1:0]  state_out;

  int checks = 0;
  int passed = 0;

  logic          inv = 1'b0;
  logic [SW-1:0] sh0_mask = '0;
  logic [SW-1:0] pipe [SB_LAT];

  logic [31:0]   busy_hist, done_hist, en_hist;
  logic [3:0]    grp_hist [32];
  logic [W-1:0]  snap;
  int            snap_cyc = 99;

  logic [W-1:0]  da, db, dc, de;
  logic [W-1:0]  zero_state = '0;

  always #5 clk = ~clk;

  masked_sbox_layer_seq #(.d(D), .PAR(PAR), .SB_LAT(SB_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .state_in  (state_in),
    .rnd_valid (rnd_valid),
    .sb_in     (sb_in),
    .sb_en     (sb_en),
    .sb_out    (sb_out),
    .busy      (busy),
    .done      (done),
    .state_out (state_out)
  );

  // S-box stub: identity or invert share 0 of every bit, SB_LAT enabled edges deep.
  always_ff @(posedge clk) begin
    if (sb_en) begin
      pipe[0] <= inv ? (sb_in ^ sh0_mask) : sb_in;
      for (int s = 1; s < int'(SB_LAT); s++) pipe[s] <= pipe[s-1];
    end
  end
  assign sb_out = pipe[SB_LAT-1];

  function automatic logic [127:0] recomb(input logic [W-1:0] s);
    logic [127:0] r;
    for (int j = 0; j < 128; j++) r[j] = ^s[j*D +: D];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_state();
    logic [W-1:0] s;
    for (int i = 0; i < int'(W / 32); i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Cycle 0 is the cycle in which start is first presented.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int sw,
                     input logic [31:0] smask, input logic [31:0] stall, input int ncyc);
    logic [127:0] r;
    busy_hist = '0;
    done_hist = '0;
    en_hist   = '0;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      start     = smask[k];
      rnd_valid = ~stall[k];
      state_in  = (k >= sw) ? b : a;
      #1;
      busy_hist[k] = busy;
      done_hist[k] = done;
      en_hist[k]   = sb_en;
      r = recomb(state_out);
      for (int g = 0; g < 4; g++) begin
        grp_hist[k][g] = (r[g*8 +: 8] == 8'hFF) && (r[32+g*8 +: 8] == 8'hFF) &&
                         (r[64+g*8 +: 8] == 8'hFF) && (r[96+g*8 +: 8] == 8'hFF);
      end
      if (k == snap_cyc) snap = state_out;
    end
    start     = 1'b0;
    rnd_valid = 1'b1;
  endtask

  initial begin
    for (int j = 0; j < int'(4 * PAR); j++) sh0_mask[j*D] = 1'b1;
    da = rnd_state();
    db = rnd_state();
    dc = rnd_state();
    de = rnd_state();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sb_en", sb_en, 0);
    check("rst_sb_in", sb_in, 0);
    check("rst_state_out", state_out, 0);
    rst_n = 1'b1;
    #1;

    // Inverting stub on all-zero shares: groups land in cycles 5..8
    inv = 1'b1;
    run(zero_state, zero_state, 99, 32'h1, 32'h0, 12);
    check("inv_done_cycle", done_hist, 32'h200);
    check("inv_group_capture", {grp_hist[9], grp_hist[8], grp_hist[7], grp_hist[6], grp_hist[5]},
          20'hF7310);
    check("inv_recombined", recomb(state_out), {128{1'b1}});

    // Identity stub, random shares
    inv = 1'b0;
    run(da, da, 99, 32'h1, 32'h0, 13);
    check("id_done_cycle", done_hist, 32'h200);
    check("id_busy", busy_hist, 32'h3FE);
    check("id_sb_en", en_hist, 32'h1FE);
    check("id_state_out", state_out, da);

    // rnd_valid low in cycles 2 and 6
    run(db, db, 99, 32'h1, 32'h44, 14);
`ifdef SBSEQ_RND_STALL_EN
    check("stall_done_cycle", done_hist, 32'h800);
    check("stall_sb_en", en_hist, 32'h7BA);
`else
    check("stall_done_cycle", done_hist, 32'h200);
    check("stall_sb_en", en_hist, 32'h1FE);
`endif
    check("stall_state_out", state_out, db);

    // start held through DONE; state_in changes mid-layer
    snap_cyc = 10;
    run(da, dc, 5, 32'h7FF, 32'h0, 24);
    check("hold_done_pulses", done_hist, 32'h80200);
    check("hold_busy", busy_hist, 32'hFFBFE);
    check("hold_first_layer", snap, da);
    check("hold_second_layer", state_out, dc);
    snap_cyc = 99;

    // Reset asserted at cycle 5 of a layer
    inv = 1'b1;
    run(de, de, 99, 32'h1, 32'h0, 5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_state_out", state_out, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sb_en", sb_en, 0);
    check("midrst_sb_in", sb_in, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    inv = 1'b0;
    run(da, da, 99, 32'h1, 32'h0, 12);
    check("postrst_done_cycle", done_hist, 32'h200);
    check("postrst_busy", busy_hist, 32'h3FE);
    check("postrst_state_out", state_out, da);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/masked_sbox_layer_seq.md
# masked_sbox_layer_seq

Sequencer that applies the masked Clyde-128 S-box layer to a full d-share 4x32-bit state using PAR external pipelined masked S-box instances. It sits directly upstream and downstream of the S-box array inside the Clyde round datapath:
- loads the shared state;
- issues column groups to the S-boxes under an enable/stall discipline;
- tracks the S-box pipeline latency;
- writes results back into an output state buffer for the linear layer.

## Interface
Parameters:
- d, 4, number of shares.
- PAR, 8, S-box instances driven in parallel; must divide 32. G = 32/PAR column groups.
- SB_LAT, 4, S-box latency in enabled clock edges.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  load state_in and begin a layer; sampled only in IDLE.
- state_in  in  128*d  shares of row r, column c at [(r*32+c)*d +: d].
- rnd_valid  in  1  fresh S-box randomness present this cycle.
- sb_in  out  4*PAR*d  lane p, bit i at [(p*4+i)*d +: d] = row i of column g*PAR+p.
- sb_en  out  1  enable to all S-box instances.
- sb_out  in  4*PAR*d  S-box results, same layout as sb_in.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when state_out is complete.
- state_out  out  128*d  result state, same layout as state_in; held until the next start.

## Operation
- The FSM has four states: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 registers state_in into the input buffer, clears the issue counter (iss) and the capture counter (cap), and moves to FEED.
  - start in any other state is ignored.
- Stall rule:
  - in FEED and DRAIN, sb_en = rnd_valid;
  - sb_en is 0 in IDLE and DONE.
  - Every counter, valid shift register and capture is frozen while sb_en=0.
- FEED:
  - sb_in presents group iss.
  - On each cycle with sb_en=1: iss increments, and a 1 is shifted into the SB_LAT-deep valid shift register vsr.
  - After issuing group G-1, the FSM moves to DRAIN.
  - Outside FEED, sb_in is driven with all-zero shares, and zeros are shifted into vsr.
- Capture:
  - On a sb_en=1 cycle with vsr[SB_LAT-1]=1, sb_out is written to the state_out group cap, and cap increments.
  - Results therefore arrive SB_LAT enabled edges after issue, in issue order.
- DRAIN: once the capture of group G-1 occurs, the FSM moves to DONE.
- DONE:
  - done=1 for exactly one cycle, then the FSM returns to IDLE.
  - A start in the DONE cycle is ignored.
- Share handling:
  - Shares are only moved or registered; no share recombination and no logic across shares in this block.
  - Only the input buffer register is read to drive sb_in, never state_in combinationally.
- Reset (including mid-layer):
  - FSM goes to IDLE; iss, cap and vsr clear; both state buffers clear to zero.
  - busy=0, done=0, sb_en=0, sb_in=0, state_out=0.
  - The S-box pipeline contents are then don't-care: vsr is cleared, so nothing stale is captured.

## Timing
- Cycle 0: start accepted.
- Cycles 1..G: FEED, absent stalls.
- Capture of group g happens in cycle 1+g+SB_LAT.
- done rises in cycle G+SB_LAT+1, which is 9 for the defaults. Each rnd_valid=0 cycle during FEED/DRAIN adds one cycle.
- state_out group g is updated at the end of its capture cycle; the whole state is valid from the done cycle onward.
- busy rises in cycle 1 and falls in the cycle after done.

## Configuration
- SBSEQ_RND_STALL_EN:
  - Defined: rnd_valid gates sb_en as described above.
  - Undefined: rnd_valid is ignored; sb_en=1 throughout FEED and DRAIN, and latency is fixed at G+SB_LAT+1. Use this only when randomness is guaranteed fresh every cycle.

## Test plan
Bench setup: behavioural S-box stub, d=4, SB_LAT=4, PAR=8.
- Identity stub, state_in = per-bit random shares, start pulse -> done at cycle 9; state_out bit-identical to state_in; busy high cycles 1..9.
- Per-lane inverting stub (output bit i = NOT input bit i on share 0), state all-zero shares -> recombined state_out = 128'hFF..FF; each group captured in cycles 5..8.
- rnd_valid=0 in cycles 2 and 6 (macro defined) -> sb_en low in those cycles; done at cycle 11; result still correct.
- Same stimulus with the macro undefined -> done at cycle 9, stalls ignored.
- start held high through the whole run and into DONE -> exactly one layer; second layer begins only at the start sampled in IDLE; done pulses once per layer.
- rst_n low at cycle 5 for one cycle, then start -> after reset, state_out=0, done=0, busy=0; the fresh run completes with correct data and no stale capture.
